// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: multi-cycle CHUNK-bit-per-clock adder/subtractor with valid/ready handshakes.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow (adds one register stage).
module seq_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH:0]   y,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
`ifdef ADDSUB_SAT_EN
  localparam logic [1:0] SAT  = 2'd3;
  localparam logic [1:0] LAST = SAT;
`else
  localparam logic [1:0] LAST = DONE;
`endif

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_addsub_unit: WIDTH must be divisible by CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
  logic [CHUNK:0]   sum;

  // Operands shift right one chunk per cycle; the result fills in from the top.
  always_comb begin
    sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = sub ? ~b : b;
        carry_d = sub ? ~cin : cin;
        a_msb_d = a[WIDTH-1];
        b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
        res_d = '0;
        ovf_d = 1'b0;
        cnt_d = '0;
        state_d = CALC;
      end
      CALC: begin
        a_d = a_q >> CHUNK;
        b_d = b_q >> CHUNK;
        res_d = (res_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = sum[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCHUNK - 1)) begin
          ovf_d = (a_msb_q == b_msb_q) & (sum[CHUNK-1] != a_msb_q);
          state_d = LAST;
        end
      end
`ifdef ADDSUB_SAT_EN
      SAT: begin
        res_d = ovf_q ? (a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : res_q;
        state_d = DONE;
      end
`endif
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q <= ovf_d;
    end
  end

  // Results are masked outside DONE so a partial sum is never visible.
  assign out_valid = state_q == DONE;
  assign in_ready  = rst_n & (state_q == IDLE);
  assign y1        = out_valid ? res_q : '0;
  assign cout      = out_valid & carry_q;
  assign ovf       = out_valid & ovf_q;
  assign y         = {cout, y1};
endmodule

// File: tb/tb_seq_addsub_unit.sv
// tb_seq_addsub_unit: directed checks of seq_addsub_unit at CHUNK = 8, 32 and 4 side by side.
module tb_seq_addsub_unit;
`ifdef ADDSUB_SAT_EN
  localparam int XL = 1;
  localparam bit SATM = 1'b1;
`else
  localparam int XL = 0;
  localparam bit SATM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready_o[3], out_valid_o[3], cout_o[3], ovf_o[3];
  logic [31:0] y1_o[3];
  logic [32:0] y_o[3];
  logic [31:0] c_y1[3];
  logic [32:0] c_y[3];
  logic c_cout[3], c_ovf[3];
  int lat[3];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_addsub_unit #(.WIDTH(32), .CHUNK(g == 0 ? 8 : g == 1 ? 32 : 4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[g]),
      .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_o[g]), .out_ready(out_ready),
      .y1(y1_o[g]), .y(y_o[g]), .cout(cout_o[g]), .ovf(ovf_o[g]));
  end

  function automatic int exp_lat(int i);
    return (i == 0 ? 4 : i == 1 ? 1 : 8) + 1 + XL;
  endfunction

  task automatic launch(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic tc);
    @(negedge clk);
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect();
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; c_y1[i] = '0; c_y[i] = '0; c_cout[i] = 1'b0; c_ovf[i] = 1'b0;
    end
    for (int n = 2; n <= 16; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (out_valid_o[i] && lat[i] == 0) begin
          lat[i] = n; c_y1[i] = y1_o[i]; c_y[i] = y_o[i]; c_cout[i] = cout_o[i]; c_ovf[i] = ovf_o[i];
        end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out_valid_o[i] !== 1'b0) begin n_err++; $display("FAIL rst_out_valid[%0d] got %b want 0", i, out_valid_o[i]); end
      n_vec++; if (in_ready_o[i] !== 1'b0) begin n_err++; $display("FAIL rst_in_ready[%0d] got %b want 0", i, in_ready_o[i]); end
      n_vec++; if (y_o[i] !== 33'h0 || ovf_o[i] !== 1'b0) begin n_err++; $display("FAIL rst_y[%0d] got %h/%b want 0/0", i, y_o[i], ovf_o[i]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (in_ready_o[i] !== 1'b1) begin n_err++; $display("FAIL idle_in_ready[%0d] got %b want 1", i, in_ready_o[i]); end
    end
  endtask

  task automatic test_add();
    launch(32'h2F049181, 32'h4070C471, 1'b0, 1'b0);
    collect();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (lat[i] != exp_lat(i)) begin n_err++; $display("FAIL add_lat[%0d] got %0d want %0d", i, lat[i], exp_lat(i)); end
      n_vec++; if (c_y1[i] !== 32'h6F7555F2) begin n_err++; $display("FAIL add_y1[%0d] got %h want 6f7555f2", i, c_y1[i]); end
    end
    n_vec++; if (c_y[0] !== 33'h06F7555F2) begin n_err++; $display("FAIL add_y got %h want 06f7555f2", c_y[0]); end
    n_vec++; if (c_cout[0] !== 1'b0 || c_ovf[0] !== 1'b0) begin n_err++; $display("FAIL add_flags got %b%b want 00", c_cout[0], c_ovf[0]); end
  endtask

  task automatic test_carry_chain();
    launch(32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
    collect();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (lat[i] != exp_lat(i)) begin n_err++; $display("FAIL carry_lat[%0d] got %0d want %0d", i, lat[i], exp_lat(i)); end
      n_vec++; if (c_y[i] !== 33'h100000001) begin n_err++; $display("FAIL carry_y[%0d] got %h want 100000001", i, c_y[i]); end
      n_vec++; if (c_cout[i] !== 1'b1 || c_ovf[i] !== 1'b0) begin n_err++; $display("FAIL carry_flags[%0d] got %b%b want 10", i, c_cout[i], c_ovf[i]); end
    end
  endtask

  task automatic test_neg_ovf();
    logic [31:0] ey;
    ey = SATM ? 32'h80000000 : 32'h2C34A6AF;
    launch(32'hABF4AAAF, 32'h803FFC00, 1'b0, 1'b0);
    collect();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (c_y[i] !== {1'b1, ey}) begin n_err++; $display("FAIL novf_y[%0d] got %h want %h", i, c_y[i], {1'b1, ey}); end
      n_vec++; if (c_cout[i] !== 1'b1 || c_ovf[i] !== 1'b1) begin n_err++; $display("FAIL novf_flags[%0d] got %b%b want 11", i, c_cout[i], c_ovf[i]); end
    end
  endtask

  task automatic test_subtract();
    logic [31:0] ey;
    launch(32'd5, 32'd7, 1'b1, 1'b0);
    collect();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (c_y[i] !== 33'h0FFFFFFFE) begin n_err++; $display("FAIL sub1_y[%0d] got %h want 0fffffffe", i, c_y[i]); end
      n_vec++; if (c_ovf[i] !== 1'b0) begin n_err++; $display("FAIL sub1_ovf[%0d] got %b want 0", i, c_ovf[i]); end
    end
    ey = SATM ? 32'h80000000 : 32'h7FFFFFFF;
    launch(32'h80000000, 32'd1, 1'b1, 1'b0);
    collect();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (c_y[i] !== {1'b1, ey}) begin n_err++; $display("FAIL sub2_y[%0d] got %h want %h", i, c_y[i], {1'b1, ey}); end
      n_vec++; if (c_ovf[i] !== 1'b1) begin n_err++; $display("FAIL sub2_ovf[%0d] got %b want 1", i, c_ovf[i]); end
    end
    launch(32'd10, 32'd3, 1'b1, 1'b1);
    collect();
    n_vec++; if (c_y[0] !== 33'h100000006) begin n_err++; $display("FAIL sub_borrow_y got %h want 100000006", c_y[0]); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    a = 32'd3; b = 32'd4; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!(out_valid_o[0] && out_valid_o[1] && out_valid_o[2]) && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    n_vec++; if (n >= 20) begin n_err++; $display("FAIL bp_wait got timeout want out_valid"); end
    a = 32'd10; b = 32'd20;
    repeat (10) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (out_valid_o[i] !== 1'b1 || in_ready_o[i] !== 1'b0) begin n_err++; $display("FAIL bp_hold[%0d] got v%b r%b want v1 r0", i, out_valid_o[i], in_ready_o[i]); end
        n_vec++; if (y_o[i] !== 33'd7) begin n_err++; $display("FAIL bp_y[%0d] got %h want 7", i, y_o[i]); end
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out_valid_o[i] !== 1'b0 || in_ready_o[i] !== 1'b1) begin n_err++; $display("FAIL hs_edge[%0d] got v%b r%b want v0 r1", i, out_valid_o[i], in_ready_o[i]); end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (in_ready_o[i] !== 1'b0) begin n_err++; $display("FAIL b2b_accept[%0d] got r%b want r0", i, in_ready_o[i]); end
    end
    collect();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (c_y[i] !== 33'd30 || lat[i] != exp_lat(i)) begin n_err++; $display("FAIL b2b_y[%0d] got %h lat %0d want 1e lat %0d", i, c_y[i], lat[i], exp_lat(i)); end
    end
  endtask

  task automatic test_reset_mid_calc();
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid_o[0] !== 1'b0 || y_o[0] !== 33'h0 || ovf_o[0] !== 1'b0) begin n_err++; $display("FAIL mid_rst_out got v%b y%h o%b want v0 y0 o0", out_valid_o[0], y_o[0], ovf_o[0]); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (in_ready_o[i] !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready[%0d] got %b want 0", i, in_ready_o[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    launch(32'd1, 32'd1, 1'b0, 1'b0);
    collect();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (c_y[i] !== 33'd2 || c_ovf[i] !== 1'b0) begin n_err++; $display("FAIL post_rst_y[%0d] got %h o%b want 2 o0", i, c_y[i], c_ovf[i]); end
      n_vec++; if (lat[i] != exp_lat(i)) begin n_err++; $display("FAIL post_rst_lat[%0d] got %0d want %0d", i, lat[i], exp_lat(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_neg_ovf();
    test_subtract();
    test_back_to_back();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
